ext_mem_merge: RTL and testbench
================================

EXT_MEM_MERGE -- requirements
Module: ext_mem_merge

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of native-bus masters merged (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; wstrb width is DATA_W/8.
REQ-004 SHALL have parameter PRIO_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority with master 0 highest.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port m_valid, input, N_MASTERS, per-master request valid.
REQ-008 SHALL have port m_addr, input, N_MASTERS*ADDR_W, packed addresses, master i at slice i.
REQ-009 SHALL have port m_wdata, input, N_MASTERS*DATA_W, packed write data.
REQ-010 SHALL have port m_wstrb, input, N_MASTERS*DATA_W/8, packed strobes; all-zero means read.
REQ-011 SHALL have port m_rdata, output, N_MASTERS*DATA_W, packed read data.
REQ-012 SHALL have port m_ready, output, N_MASTERS, per-master one-cycle completion pulse.
REQ-013 SHALL have ports s_valid/s_addr/s_wdata/s_wstrb, outputs, 1/ADDR_W/DATA_W/DATA_W/8, merged slave request.
REQ-014 SHALL have ports s_rdata/s_ready, inputs, DATA_W/1, slave response; s_ready is a one-cycle pulse.
REQ-015 SHALL have port inv_req, input, 1, one-cycle request to invalidate the downstream cache.
REQ-016 SHALL have port inv_o, output, 1, one-cycle invalidate strobe to the downstream cache.
REQ-017 SHALL have port inv_busy, output, 1, high while an invalidate is pending or being issued.

Function
REQ-018 SHALL implement an FSM with states IDLE, BUSY, INV and registers grant (index), rr_ptr (index), inv_pending.
REQ-019 In IDLE with inv_pending=1, SHALL go to INV regardless of m_valid; invalidate has priority over new grants.
REQ-020 In IDLE with inv_pending=0 and any m_valid bit set, SHALL register the winner in grant and go to BUSY.
REQ-021 PRIO_MODE=0: winner SHALL be the first set m_valid bit searching upward from rr_ptr, wrapping modulo N_MASTERS.
REQ-022 PRIO_MODE=1: winner SHALL be the lowest-index set m_valid bit; rr_ptr unused.
REQ-023 In BUSY, s_valid SHALL equal m_valid[grant]; s_addr, s_wdata and s_wstrb SHALL be master grant's slices. Outside BUSY, s_valid SHALL be 0.
REQ-024 Masters SHALL hold valid and request fields stable until their m_ready; behaviour on violation is undefined.
REQ-025 On s_ready in BUSY, m_ready[grant] SHALL pulse in the same cycle, the FSM SHALL return to IDLE, and rr_ptr SHALL become (grant+1) mod N_MASTERS.
REQ-026 m_ready[i] SHALL be 0 for every i other than grant; s_rdata SHALL be broadcast to all m_rdata slices.
REQ-027 Request-to-s_valid latency SHALL be exactly one cycle from IDLE; back-to-back grants SHALL have one IDLE cycle between transactions.
REQ-028 inv_req=1 SHALL set inv_pending in any state, including the same cycle as s_ready or during INV, where it queues one further invalidate.
REQ-029 In INV, inv_o SHALL be 1 for exactly one cycle; inv_pending SHALL clear unless inv_req=1 that cycle; the FSM SHALL then go to IDLE.
REQ-030 An invalidate SHALL never be issued while s_valid=1; a BUSY transaction SHALL always complete first.
REQ-031 inv_busy SHALL equal inv_pending OR (state==INV).
REQ-032 s_ready outside BUSY SHALL be ignored.

Reset
REQ-033 On rst, state SHALL be IDLE, grant=0, rr_ptr=0, inv_pending=0; s_valid, m_ready, inv_o and inv_busy SHALL be 0 the same cycle, with no clock edge needed.
REQ-034 rst asserted mid-transaction SHALL abandon it with no m_ready pulse; a pending invalidate SHALL be discarded.

Verification
REQ-035 Single read: m_valid=01, m_addr[0]=0x100, slave ready after 3 cycles with rdata 0xCAFE -> s_valid from cycle 1, m_ready=01 with m_rdata[0]=0xCAFE, rr_ptr=1.
REQ-036 Round-robin, N=2: m_valid=11 held continuously -> grants alternate 0,1,0,1; each master gets one completion per two transactions.
REQ-037 Fixed priority: PRIO_MODE=1, m_valid=11 held -> only master 0 is served while it keeps requesting.
REQ-038 Invalidate during BUSY: inv_req during master 1 write -> inv_o stays 0 until after m_ready[1]; next cycle IDLE, then inv_o pulses once before any new grant.
REQ-039 Double invalidate: inv_req in IDLE and again during INV -> inv_o pulses exactly twice, with inv_busy high throughout.
REQ-040 Reset mid-op: rst during BUSY -> s_valid=0 and m_ready=0 immediately; after release the first request is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/ext_mem_merge.sv
// Merges N native-bus masters onto one slave port with round-robin or fixed
// priority arbitration, and sequences downstream cache invalidates between transactions.
module ext_mem_merge #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  localparam int SW = DATA_W / 8,
  localparam int IW = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*SW-1:0]     m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0] m_rdata,
  output logic [N_MASTERS-1:0]        m_ready,
  output logic                        s_valid,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [SW-1:0]               s_wstrb,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic                        s_ready,
  input  logic                        inv_req,
  output logic                        inv_o,
  output logic                        inv_busy,
  output logic [1:0]                  dbg_state,
  output logic [IW-1:0]               dbg_grant,
  output logic [IW-1:0]               dbg_rr_ptr
);

  // Handshake: a master raises m_valid and holds its request fields until the
  // single-cycle m_ready pulse; the slave completes a held s_valid with one s_ready pulse.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_INV = 2'd2} state_t;

  state_t        r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic          r_inv_pending;

  logic [2*N_MASTERS-1:0] w_rot;
  logic [IW-1:0]          w_base;
  logic [IW-1:0]          w_win;
  logic [IW:0]            w_sum;
  logic                   w_found;
  logic                   w_busy;
  logic                   w_sel_valid;

  assign w_busy = (r_state == ST_BUSY);

  // Rotate the request vector so the search always starts at bit 0, then map back.
  always_comb begin
    w_base  = (PRIO_MODE != 0) ? '0 : r_rr_ptr;
    w_rot   = {m_valid, m_valid} >> w_base;
    w_found = |m_valid;
    w_sum   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_sum = {1'b0, w_base} + (IW+1)'(k);
    end
    if (w_sum >= (IW+1)'(N_MASTERS)) w_win = IW'(w_sum - (IW+1)'(N_MASTERS));
    else                             w_win = IW'(w_sum);
  end

  always_comb begin
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    w_sel_valid = 1'b0;
    m_ready     = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant == IW'(i)) begin
        s_addr      = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata     = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb     = m_wstrb[i*SW +: SW];
        w_sel_valid = m_valid[i];
        m_ready[i]  = w_busy & s_ready;
      end
    end
  end

  assign s_valid    = w_busy & w_sel_valid;
  assign m_rdata    = {N_MASTERS{s_rdata}};
  assign inv_o      = (r_state == ST_INV);
  assign inv_busy   = r_inv_pending | (r_state == ST_INV);
  assign dbg_state  = r_state;
  assign dbg_grant  = r_grant;
  assign dbg_rr_ptr = r_rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_inv_pending <= 1'b0;
    end else begin
      // A request arriving during INV re-arms pending, queuing one more invalidate.
      r_inv_pending <= inv_req | (r_inv_pending & (r_state != ST_INV));
      case (r_state)
        ST_IDLE: begin
          if (r_inv_pending) begin
            r_state <= ST_INV;
          end else if (w_found) begin
            r_grant <= w_win;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            r_state <= ST_IDLE;
            if (r_grant == IW'(N_MASTERS - 1)) r_rr_ptr <= '0;
            else                               r_rr_ptr <= r_grant + 1'b1;
          end
        end
        ST_INV:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_merge.sv
// Directed bench for ext_mem_merge: round-robin and fixed-priority instances
// share stimulus; a vector table covers arbitration, sequences cover invalidate and reset.
module tb_ext_mem_merge;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            inv_req;

  logic [N*DW-1:0] rr_m_rdata, fp_m_rdata;
  logic [N-1:0]    rr_m_ready, fp_m_ready;
  logic            rr_s_valid, fp_s_valid;
  logic [AW-1:0]   rr_s_addr, fp_s_addr;
  logic [DW-1:0]   rr_s_wdata, fp_s_wdata;
  logic [SW-1:0]   rr_s_wstrb, fp_s_wstrb;
  logic            rr_inv_o, fp_inv_o, rr_inv_busy, fp_inv_busy;
  logic [1:0]      rr_state, fp_state;
  logic [0:0]      rr_grant, fp_grant, rr_ptr, fp_ptr;

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_INV = 2'd2;

  always #5 clk = ~clk;

  ext_mem_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(rr_m_rdata), .m_ready(rr_m_ready), .s_valid(rr_s_valid),
    .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .inv_req(inv_req), .inv_o(rr_inv_o), .inv_busy(rr_inv_busy),
    .dbg_state(rr_state), .dbg_grant(rr_grant), .dbg_rr_ptr(rr_ptr)
  );

  ext_mem_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(fp_m_rdata), .m_ready(fp_m_ready), .s_valid(fp_s_valid),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .inv_req(inv_req), .inv_o(fp_inv_o), .inv_busy(fp_inv_busy),
    .dbg_state(fp_state), .dbg_grant(fp_grant), .dbg_rr_ptr(fp_ptr)
  );

  int total = 0;
  int bad   = 0;
  int inv_pulses = 0;

  always @(negedge clk) if (rr_inv_o === 1'b1) inv_pulses++;

  typedef struct {
    logic [1:0]  mv;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  w0, w1;
    int          wait_c;
    logic [31:0] rd;
    int          g_rr, g_fp, rr_after;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(logic [1:0] mv, logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic [3:0] w0,
                              logic [3:0] w1, int wait_c, logic [31:0] rd,
                              int g_rr, int g_fp, int rr_after);
    vec_t v;
    v.mv = mv; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.w0 = w0; v.w1 = w1;
    v.wait_c = wait_c; v.rd = rd; v.g_rr = g_rr; v.g_fp = g_fp; v.rr_after = rr_after;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, f0, p0;
    logic [31:0] ea, ed;
    logic [3:0]  ew;

    vecs[0] = mk(2'b01, 32'h100, 32'h0,   32'h0,  32'h0,  4'h0, 4'h0, 3, 32'hCAFE, 0, 0, 1);
    vecs[1] = mk(2'b11, 32'h104, 32'h204, 32'h11, 32'h22, 4'h0, 4'hF, 2, 32'h1234, 1, 0, 0);
    vecs[2] = mk(2'b11, 32'h108, 32'h208, 32'h33, 32'h44, 4'h3, 4'h0, 1, 32'h5678, 0, 0, 1);
    vecs[3] = mk(2'b01, 32'h10C, 32'h0,   32'hAB, 32'h0,  4'h1, 4'h0, 2, 32'h9ABC, 0, 0, 1);
    vecs[4] = mk(2'b10, 32'h0,   32'h210, 32'h0,  32'hCD, 4'h0, 4'hC, 1, 32'hDEF0, 1, 1, 0);
    vecs[5] = mk(2'b10, 32'h0,   32'h214, 32'h0,  32'hEF, 4'h0, 4'h8, 2, 32'h0F0F, 1, 1, 0);

    rst = 1'b0; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0; inv_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_state", rr_state, S_IDLE);
    chk("reset_s_valid", rr_s_valid, 0);
    chk("reset_m_ready", rr_m_ready, 0);
    chk("reset_inv", {rr_inv_o, rr_inv_busy}, 0);
    chk("reset_grant_ptr", {rr_grant, rr_ptr}, 0);
    tick; tick;
    rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      m_valid = vecs[i].mv;
      m_addr  = {vecs[i].a1, vecs[i].a0};
      m_wdata = {vecs[i].d1, vecs[i].d0};
      m_wstrb = {vecs[i].w1, vecs[i].w0};
      ea = (vecs[i].g_rr == 0) ? vecs[i].a0 : vecs[i].a1;
      ed = (vecs[i].g_rr == 0) ? vecs[i].d0 : vecs[i].d1;
      ew = (vecs[i].g_rr == 0) ? vecs[i].w0 : vecs[i].w1;
      tick;
      chk($sformatf("v%0d_s_valid", i), rr_s_valid, 1);
      chk($sformatf("v%0d_grant", i), rr_grant, vecs[i].g_rr);
      chk($sformatf("v%0d_s_addr", i), rr_s_addr, ea);
      chk($sformatf("v%0d_s_wdata", i), rr_s_wdata, ed);
      chk($sformatf("v%0d_s_wstrb", i), rr_s_wstrb, ew);
      chk($sformatf("v%0d_fp_grant", i), fp_grant, vecs[i].g_fp);
      for (int w = 1; w < vecs[i].wait_c; w++) tick;
      chk($sformatf("v%0d_no_early_ready", i), rr_m_ready, 0);
      s_rdata = vecs[i].rd;
      s_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_m_ready", i), rr_m_ready, 64'(1) << vecs[i].g_rr);
      chk($sformatf("v%0d_m_rdata", i), rr_m_rdata, {vecs[i].rd, vecs[i].rd});
      chk($sformatf("v%0d_fp_m_ready", i), fp_m_ready, 64'(1) << vecs[i].g_fp);
      tick;
      s_ready = 1'b0;
      m_valid = '0;
      chk($sformatf("v%0d_idle", i), {rr_state, rr_s_valid}, {S_IDLE, 1'b0});
      chk($sformatf("v%0d_rr_ptr", i), rr_ptr, vecs[i].rr_after);
    end

    // Both masters held: rr alternates, fixed priority keeps serving master 0
    c0 = 0; c1 = 0; f0 = 0;
    m_valid = 2'b11;
    m_addr  = {32'h300, 32'h400};
    for (int t = 0; t < 4; t++) begin
      tick;
      chk($sformatf("held%0d_grant", t), rr_grant, t % 2);
      chk($sformatf("held%0d_fp_grant", t), fp_grant, 0);
      s_ready = 1'b1;
      #1;
      if (rr_m_ready[0]) c0++;
      if (rr_m_ready[1]) c1++;
      if (fp_m_ready[0]) f0++;
      tick;
      s_ready = 1'b0;
      chk($sformatf("held%0d_idle_gap", t), rr_state, S_IDLE);
    end
    m_valid = '0;
    chk("held_count_m0", c0, 2);
    chk("held_count_m1", c1, 2);
    chk("held_fp_count_m0", f0, 4);

    // s_ready outside BUSY is ignored
    s_ready = 1'b1;
    #1;
    chk("stray_ready_m_ready", rr_m_ready, 0);
    tick;
    s_ready = 1'b0;
    chk("stray_ready_state", rr_state, S_IDLE);

    // Invalidate raised during a master 1 write
    m_valid = 2'b10;
    m_addr  = {32'h200, 32'h0};
    m_wdata = {32'h55, 32'h0};
    m_wstrb = {4'hF, 4'h0};
    tick;
    chk("inv_busy_grant", rr_grant, 1);
    inv_req = 1'b1;
    tick;
    inv_req = 1'b0;
    chk("inv_during_busy", {rr_inv_busy, rr_inv_o, rr_s_valid}, 3'b101);
    tick;
    chk("inv_held_off", rr_inv_o, 0);
    s_ready = 1'b1;
    #1;
    chk("inv_wr_m_ready", {rr_m_ready, rr_inv_o}, 3'b100);
    tick;
    s_ready = 1'b0;
    m_valid = 2'b11;
    chk("inv_after_idle", {rr_state, rr_inv_o, rr_s_valid}, {S_IDLE, 2'b00});
    tick;
    chk("inv_pulse", {rr_state, rr_inv_o, rr_s_valid}, {S_INV, 2'b10});
    tick;
    chk("inv_done", {rr_state, rr_inv_o, rr_inv_busy}, {S_IDLE, 2'b00});
    tick;
    chk("inv_then_grant", {rr_state, rr_grant}, {S_BUSY, 1'b0});
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    m_valid = '0;

    // Double invalidate: second request lands during INV
    p0 = inv_pulses;
    inv_req = 1'b1;
    tick;
    inv_req = 1'b0;
    chk("dinv_pending", {rr_inv_busy, rr_inv_o}, 2'b10);
    tick;
    chk("dinv_first", {rr_state, rr_inv_o, rr_inv_busy}, {S_INV, 2'b11});
    inv_req = 1'b1;
    tick;
    inv_req = 1'b0;
    chk("dinv_gap", {rr_inv_o, rr_inv_busy}, 2'b01);
    tick;
    chk("dinv_second", {rr_state, rr_inv_o, rr_inv_busy}, {S_INV, 2'b11});
    tick;
    chk("dinv_clear", {rr_inv_o, rr_inv_busy}, 2'b00);
    tick;
    chk("dinv_pulse_count", inv_pulses - p0, 2);

    // Reset in the middle of a transaction with an invalidate queued
    m_valid = 2'b11;
    m_addr  = {32'h500, 32'h600};
    tick;
    chk("rst_pre_grant", {rr_state, rr_grant, rr_ptr}, {S_BUSY, 1'b1, 1'b1});
    inv_req = 1'b1;
    tick;
    inv_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out", {rr_s_valid, rr_m_ready, rr_inv_o, rr_inv_busy}, 0);
    chk("rst_async_regs", {rr_state, rr_grant, rr_ptr}, 0);
    s_ready = 1'b1;
    #1;
    chk("rst_no_m_ready", rr_m_ready, 0);
    tick;
    s_ready = 1'b0;
    rst = 1'b0;
    tick;
    chk("rst_rearb", {rr_state, rr_grant, rr_inv_busy}, {S_BUSY, 1'b0, 1'b0});
    chk("rst_rearb_addr", rr_s_addr, 32'h600);
    s_ready = 1'b1;
    #1;
    chk("rst_rearb_ready", rr_m_ready, 2'b01);
    tick;
    s_ready = 1'b0;
    m_valid = '0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
